ahb_slave_if: RTL and testbench

Upstream stage of the AHB-to-APB bridge. It accepts AHB-Lite transfers and buffers them in a small in-order request queue. It drives the APB master's request inputs (`transfer`, `addr_temp`, `data_temp`, `write_enable`) and returns APB read data to the AHB bus. Writes are posted: zero wait states while the queue has room. Reads stall the AHB data phase until the APB read completes.

---
 rtl/ahb_slave_if_if.sv | 35 +++
 rtl/ahb_slave_if.sv | 128 ++++++++++++
 tb/tb_ahb_slave_if.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_if_if.sv
// ahb_slave_if_if: bundles the AHB-Lite slave signals and the APB-master request
// and response signals of the bridge's upstream stage.
//   slave  modport: used by ahb_slave_if (AHB inputs, APB response in;
//                   AHB response, APB request out)
//   master modport: used by the surrounding bus or a testbench to drive the slave
interface ahb_slave_if_if #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32
);
  logic             Hsel;
  logic [ASIZE-1:0] Haddr;
  logic [1:0]       Htrans;
  logic             Hwrite;
  logic [DSIZE-1:0] Hwdata;
  logic             Hready_in;
  logic             Hreadyout;
  logic [1:0]       Hresp;
  logic [DSIZE-1:0] Hrdata;
  logic             transfer;
  logic [ASIZE-1:0] addr_temp;
  logic [DSIZE-1:0] data_temp;
  logic             write_enable;
  logic             xfer_done;
  logic [DSIZE-1:0] rdata_temp;

  modport slave (
    input  Hsel, Haddr, Htrans, Hwrite, Hwdata, Hready_in, xfer_done, rdata_temp,
    output Hreadyout, Hresp, Hrdata, transfer, addr_temp, data_temp, write_enable
  );

  modport master (
    output Hsel, Haddr, Htrans, Hwrite, Hwdata, Hready_in, xfer_done, rdata_temp,
    input  Hreadyout, Hresp, Hrdata, transfer, addr_temp, data_temp, write_enable
  );
endinterface

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB-Lite front end of the AHB-to-APB bridge.
// Captures AHB transfers into a small in-order request queue that feeds the APB
// master. Writes are posted (no wait states while the queue has room); reads
// stall the AHB data phase until the APB read returns.
// Ports:
//   Hclk   - single clock shared by the AHB side and the APB master
//   Hreset - synchronous active-high reset
//   bus    - ahb_slave_if_if.slave: AHB slave signals plus the APB request
//            (transfer/addr_temp/data_temp/write_enable) and the APB
//            completion (xfer_done/rdata_temp)
module ahb_slave_if #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32,
  parameter int DEPTH = 2
) (
  input logic            Hclk,
  input logic            Hreset,
  ahb_slave_if_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ASIZE-1:0] q_addr [DEPTH];
  logic [DSIZE-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_write;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             dp_valid;
  logic             dp_write;
  logic [ASIZE-1:0] dp_addr;
  logic             rd_pend;
  logic [DSIZE-1:0] hrdata_q;

  logic not_empty;
  logic pop;
  logic can_accept;
  logic push_wr;
  logic push_rd;
  logic push;
  logic rd_done;
  logic addr_capture;
  logic hready;

  assign not_empty    = (count != '0);
  assign pop          = bus.xfer_done & not_empty;
  // A full queue still accepts when the head leaves in the same cycle.
  assign can_accept   = (count < CW'(DEPTH)) | pop;
  assign push_wr      = dp_valid & dp_write & can_accept;
  assign push_rd      = dp_valid & ~dp_write & ~rd_pend & can_accept;
  assign push         = push_wr | push_rd;
  // Only one read can be queued and it is always behind the writes, so a pop
  // of a read-direction head entry is that read completing.
  assign rd_done      = rd_pend & pop & ~q_write[rd_ptr];
  assign addr_capture = bus.Hsel & bus.Hready_in & bus.Htrans[1];

  always_comb begin
    hready = 1'b1;
    if (dp_valid) begin
      hready = dp_write ? can_accept : 1'b0;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      rd_pend  <= 1'b0;
      hrdata_q <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      // The read stall holds Hready_in low, so the read's completion has to
      // retire the data phase explicitly.
      if (rd_done) begin
        dp_valid <= 1'b0;
      end else if (addr_capture) begin
        dp_valid <= 1'b1;
        dp_addr  <= bus.Haddr;
        dp_write <= bus.Hwrite;
      end else if (bus.Hready_in) begin
        dp_valid <= 1'b0;
      end

      if (push_rd) begin
        rd_pend <= 1'b1;
      end else if (rd_done) begin
        rd_pend <= 1'b0;
      end

      if (rd_done) begin
        hrdata_q <= bus.rdata_temp;
      end

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge Hclk) begin
    if (push) begin
      q_addr[wr_ptr]  <= dp_addr;
      q_data[wr_ptr]  <= dp_write ? bus.Hwdata : '0;
      q_write[wr_ptr] <= dp_write;
    end
  end

  // The entry being popped must not look like a fresh request to the APB
  // master, which samples transfer in its completion cycle.
  assign bus.transfer     = (count > CW'(1)) | ((count == CW'(1)) & ~bus.xfer_done);
  assign bus.addr_temp    = not_empty ? q_addr[rd_ptr] : '0;
  assign bus.data_temp    = not_empty ? q_data[rd_ptr] : '0;
  assign bus.write_enable = not_empty & q_write[rd_ptr];
  assign bus.Hreadyout    = hready;
  assign bus.Hresp        = 2'b00;
  assign bus.Hrdata       = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb_ahb_slave_if: per-cycle vector table for ahb_slave_if (inputs driven just
// after the rising edge, outputs compared on the falling edge), followed by a
// hand-sequenced read against a zero-wait-state APB responder.
module tb_ahb_slave_if;

  logic Hclk = 1'b0;
  logic Hreset;
  logic hr_force;

  always #5 Hclk = ~Hclk;

  ahb_slave_if_if #(.ASIZE(32), .DSIZE(32)) bus ();

  // Single-slave bus: HREADY is this slave's ready unless a row forces it low.
  assign bus.Hready_in = hr_force ? 1'b0 : bus.Hreadyout;

  ahb_slave_if #(.ASIZE(32), .DSIZE(32), .DEPTH(2)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  typedef struct {
    bit          chk;
    bit          rst;
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          hr0;
    bit          xd;
    logic [31:0] rdata;
    bit          e_rdy;
    bit          e_tr;
    logic [31:0] e_at;
    logic [31:0] e_dt;
    bit          e_we;
    logic [31:0] e_hrd;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;
  int   apb;
  int   waits;
  bit   done;

  function automatic vec_t mk(bit chk, bit rst, bit sel, logic [1:0] trans, bit wr,
                              logic [31:0] addr, logic [31:0] wdata, bit hr0, bit xd,
                              logic [31:0] rdata, bit e_rdy, bit e_tr, logic [31:0] e_at,
                              logic [31:0] e_dt, bit e_we, logic [31:0] e_hrd);
    vec_t v;
    v.chk = chk; v.rst = rst; v.sel = sel; v.trans = trans; v.wr = wr;
    v.addr = addr; v.wdata = wdata; v.hr0 = hr0; v.xd = xd; v.rdata = rdata;
    v.e_rdy = e_rdy; v.e_tr = e_tr; v.e_at = e_at; v.e_dt = e_dt; v.e_we = e_we;
    v.e_hrd = e_hrd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(vec_t v);
    Hreset         = v.rst;
    bus.Hsel       = v.sel;
    bus.Htrans     = v.trans;
    bus.Hwrite     = v.wr;
    bus.Haddr      = v.addr;
    bus.Hwdata     = v.wdata;
    hr_force       = v.hr0;
    bus.xfer_done  = v.xd;
    bus.rdata_temp = v.rdata;
  endtask

  task automatic check_row(int i, vec_t v);
    chk($sformatf("r%0d_hreadyout", i), 32'(bus.Hreadyout), 32'(v.e_rdy));
    chk($sformatf("r%0d_transfer", i), 32'(bus.transfer), 32'(v.e_tr));
    chk($sformatf("r%0d_addr_temp", i), bus.addr_temp, v.e_at);
    chk($sformatf("r%0d_data_temp", i), bus.data_temp, v.e_dt);
    chk($sformatf("r%0d_write_enable", i), 32'(bus.write_enable), 32'(v.e_we));
    chk($sformatf("r%0d_hrdata", i), bus.Hrdata, v.e_hrd);
    chk($sformatf("r%0d_hresp", i), 32'(bus.Hresp), 32'd0);
  endtask

  localparam logic [31:0] C = 32'hCAFE_0001;
  localparam logic [31:0] D = 32'hDEAD_BEEF;

  initial begin
    n_pass  = 0;
    n_total = 0;

    //              chk rst sel trn  wr addr    wdata  hr0 xd rdata | rdy tr at      dt    we hrd
    // reset state
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    // single posted write
    vecs.push_back(mk(1, 0, 1, 2'd2, 1, 32'h10, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, D,      0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 1, 32'h10, D,      1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 1, 32'h0, 1, 0, 32'h10, D,      1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    // three SEQ writes, queue fills, third data phase stalls
    vecs.push_back(mk(1, 0, 1, 2'd3, 1, 32'h20, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 1, 2'd3, 1, 32'h24, 32'hA0, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 1, 2'd3, 1, 32'h28, 32'hA4, 0, 0, 32'h0, 1, 1, 32'h20, 32'hA0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'hA8, 0, 0, 32'h0, 0, 1, 32'h20, 32'hA0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'hA8, 0, 0, 32'h0, 0, 1, 32'h20, 32'hA0, 1, 32'h0));
    // full queue with pop: push accepted, transfer stays high (two entries)
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'hA8, 0, 1, 32'h0, 1, 1, 32'h20, 32'hA0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 1, 32'h24, 32'hA4, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 1, 32'h0, 1, 1, 32'h24, 32'hA4, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 1, 32'h28, 32'hA8, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 1, 32'h0, 1, 0, 32'h28, 32'hA8, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    // read behind a posted write
    vecs.push_back(mk(1, 0, 1, 2'd2, 1, 32'h30, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 1, 2'd2, 0, 32'h34, 32'h11, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 0, 1, 32'h30, 32'h11, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 0, 1, 32'h30, 32'h11, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 1, 32'h0, 0, 1, 32'h30, 32'h11, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 0, 1, 32'h34, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 1, C,     0, 0, 32'h34, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    // IDLE, BUSY and NONSEQ-without-HREADY are not queued
    vecs.push_back(mk(1, 0, 1, 2'd0, 1, 32'h40, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 0, 1, 2'd1, 1, 32'h44, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 0, 1, 2'd2, 1, 32'h48, 32'h00, 1, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h55, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    // xfer_done with an empty queue is ignored
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 1, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 0, 1, 2'd2, 1, 32'h50, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h77, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 1, 32'h50, 32'h77, 1, C));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 1, 32'h0, 1, 0, 32'h50, 32'h77, 1, C));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, C));
    // reset held two cycles during a write stall
    vecs.push_back(mk(0, 0, 1, 2'd2, 1, 32'h60, 32'h00, 0, 0, 32'h0, 0, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(0, 0, 1, 2'd3, 1, 32'h64, 32'h01, 0, 0, 32'h0, 0, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(0, 0, 1, 2'd3, 1, 32'h68, 32'h02, 0, 0, 32'h0, 0, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h03, 0, 0, 32'h0, 0, 1, 32'h60, 32'h01, 1, C));
    vecs.push_back(mk(0, 1, 0, 2'd0, 0, 32'h00, 32'h03, 0, 0, 32'h0, 0, 0, 32'h00, 32'h00, 0, C));
    vecs.push_back(mk(1, 1, 0, 2'd0, 0, 32'h00, 32'h03, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 2'd0, 0, 32'h00, 32'h00, 0, 0, 32'h0, 1, 0, 32'h00, 32'h00, 0, 32'h0));

    drive(mk(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge Hclk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge Hclk);
      if (vecs[i].chk) check_row(i, vecs[i]);
      @(posedge Hclk);
      #1;
    end

    // Read against a zero-wait-state APB responder: expect four wait states.
    bus.Hsel = 1'b1; bus.Htrans = 2'd2; bus.Hwrite = 1'b0; bus.Haddr = 32'h70;
    bus.xfer_done = 1'b0; bus.rdata_temp = 32'h1234_5678;
    @(posedge Hclk);
    #1;
    bus.Hsel = 1'b0; bus.Htrans = 2'd0;
    apb = 0; waits = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      bus.xfer_done = (apb == 2);
      @(negedge Hclk);
      if (bus.Hreadyout) begin
        done = 1'b1;
      end else begin
        waits++;
        if (apb == 1) apb = 2;
        else apb = bus.transfer ? 1 : 0;
        @(posedge Hclk);
        #1;
      end
    end
    chk("rd_timeout", 32'(done), 32'd1);
    chk("rd_wait_states", 32'(waits), 32'd4);
    chk("rd_hrdata", bus.Hrdata, 32'h1234_5678);
    chk("rd_transfer_after", 32'(bus.transfer), 32'd0);
    bus.xfer_done = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
